axioma_adc_trigger: RTL and testbench



---
 rtl/axioma_adc_pkg.sv | 39 +++
 rtl/axioma_edge_det.sv | 36 +++
 rtl/axioma_adc_trigger.sv | 151 +++++++++++++++
 tb/tb_axioma_adc_trigger.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axioma_adc_pkg.sv
// -----------------------------------------------------------------------------
// axioma_adc_pkg
// Shared definitions for the ADC subsystem: the ADTS trigger-source encodings
// (ATmega328P ADCSRB[2:0] compatible), the ADC register map addresses and the
// control-bit positions used by both the trigger unit and the ADC controller.
// -----------------------------------------------------------------------------
package axioma_adc_pkg;

   // Number of selectable auto-trigger sources.
   localparam int NUM_TRIG_SRC = 8;

   // ADTS encodings. The numeric value is also the bit index of the source
   // in the trigger unit's source vector.
   typedef enum logic [2:0] {
      ADTS_FREE  = 3'd0,   // free-running: retrigger on conversion complete
      ADTS_ACOMP = 3'd1,   // analog comparator
      ADTS_INT0  = 3'd2,   // external interrupt request 0
      ADTS_T0CMA = 3'd3,   // Timer/Counter0 compare match A
      ADTS_T0OVF = 3'd4,   // Timer/Counter0 overflow
      ADTS_T1CMB = 3'd5,   // Timer/Counter1 compare match B
      ADTS_T1OVF = 3'd6,   // Timer/Counter1 overflow
      ADTS_T1CAP = 3'd7    // Timer/Counter1 capture event
   } adts_e;

   // ADC register addresses in the data-memory I/O map.
   localparam logic [7:0] ADDR_ADCL   = 8'h78;
   localparam logic [7:0] ADDR_ADCH   = 8'h79;
   localparam logic [7:0] ADDR_ADCSRA = 8'h7A;
   localparam logic [7:0] ADDR_ADCSRB = 8'h7B;
   localparam logic [7:0] ADDR_ADMUX  = 8'h7C;
   localparam logic [7:0] ADDR_DIDR0  = 8'h7E;

   // Control-bit positions inside ADCSRA / ADCSRB.
   localparam int ADCSRA_ADEN  = 7;
   localparam int ADCSRA_ADSC  = 6;
   localparam int ADCSRA_ADATE = 5;
   localparam int ADCSRB_ADTS0 = 0;

endpackage : axioma_adc_pkg

// File: rtl/axioma_edge_det.sv
// -----------------------------------------------------------------------------
// axioma_edge_det
// Per-bit rising-edge detector. Every bit keeps its own previous-value
// register, updated every cycle, so a bit only reports an edge on a genuine
// 0->1 transition of that same bit.
//
// Ports
//   clk      : system clock
//   reset_n  : asynchronous active-low reset (previous values cleared to 0)
//   din      : WIDTH level inputs
//   rise     : WIDTH combinational edge flags, rise[i] = din[i] & ~prev[i]
// -----------------------------------------------------------------------------
module axioma_edge_det #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] prev;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev <= '0;
      end else begin
         prev <= din;
      end
   end

   assign rise = din & ~prev;

endmodule : axioma_edge_det

// File: rtl/axioma_adc_trigger.sv
// -----------------------------------------------------------------------------
// axioma_adc_trigger
// ADC auto-trigger source unit. Selects one of eight trigger sources with
// ADTS, detects its rising edge, holds one pending request and issues a
// one-cycle registered start pulse to the ADC controller whenever the ADC is
// idle. Issued triggers are counted (wrapping); edges that arrive while a
// request is already pending are lost and counted as overruns (saturating).
//
// Ports
//   clk, reset_n  : system clock, asynchronous active-low reset
//   adts          : trigger source select (ADCSRB[2:0])
//   adate, aden   : auto-trigger enable, ADC enable; unit armed when both set
//   adc_busy      : ADC controller not idle
//   adc_done      : one-cycle conversion-complete pulse (free-running source)
//   acomp_out     : analog comparator output
//   int0_flag     : external interrupt 0 flag
//   tc0_compa     : Timer0 compare-match A flag
//   tc0_ovf       : Timer0 overflow flag
//   tc1_compb     : Timer1 compare-match B flag
//   tc1_ovf       : Timer1 overflow flag
//   tc1_capt      : Timer1 input-capture flag
//   ovr_clr       : one-cycle pulse clearing overrun and ovr_count
//   adc_trigger   : one-cycle registered start pulse to the ADC
//   pending       : a request is latched and not yet issued
//   overrun       : sticky lost-edge flag
//   ovr_count     : number of lost edges, saturating at all-ones
//   trig_count    : number of issued triggers, wrapping
// -----------------------------------------------------------------------------
module axioma_adc_trigger
   import axioma_adc_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int OVR_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       adts,
   input  logic             adate,
   input  logic             aden,
   input  logic             adc_busy,
   input  logic             adc_done,
   input  logic             acomp_out,
   input  logic             int0_flag,
   input  logic             tc0_compa,
   input  logic             tc0_ovf,
   input  logic             tc1_compb,
   input  logic             tc1_ovf,
   input  logic             tc1_capt,
   input  logic             ovr_clr,
   output logic             adc_trigger,
   output logic             pending,
   output logic             overrun,
   output logic [OVR_W-1:0] ovr_count,
   output logic [CNT_W-1:0] trig_count
);

   // ---------------------------------------------------------------------
   // Source vector and edge detection
   // ---------------------------------------------------------------------
   logic [NUM_TRIG_SRC-1:0] src;
   logic [NUM_TRIG_SRC-1:0] rise;

   always_comb begin
      src             = '0;
      src[ADTS_FREE]  = adc_done;
      src[ADTS_ACOMP] = acomp_out;
      src[ADTS_INT0]  = int0_flag;
      src[ADTS_T0CMA] = tc0_compa;
      src[ADTS_T0OVF] = tc0_ovf;
      src[ADTS_T1CMB] = tc1_compb;
      src[ADTS_T1OVF] = tc1_ovf;
      src[ADTS_T1CAP] = tc1_capt;
   end

   // All eight detectors run every cycle, so switching adts onto a source
   // that is already high does not look like an edge.
   axioma_edge_det #(
      .WIDTH (NUM_TRIG_SRC)
   ) u_edge_det (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (src),
      .rise    (rise)
   );

   // ---------------------------------------------------------------------
   // Request / issue decision
   // ---------------------------------------------------------------------
   logic armed;
   logic sel_edge;
   logic issue;
   logic lost_edge;
   logic pending_nxt;

   assign armed    = aden & adate;
   assign sel_edge = rise[adts];

   // adc_busy is only registered by the ADC the cycle after our pulse, so
   // the ~adc_trigger term forces at least one idle cycle between pulses.
   assign issue = armed & pending & ~adc_busy & ~adc_trigger;

   // An edge arriving while the held request is being issued simply
   // re-arms the request; only an edge that cannot be held is lost.
   assign lost_edge = armed & sel_edge & pending & ~issue;

   // NOTE: the default assignment first guarantees pending_nxt is driven on
   // every path, so no latch is inferred.
   always_comb begin
      pending_nxt = pending;
      if (!armed) begin
         pending_nxt = 1'b0;
      end else if (issue) begin
         pending_nxt = sel_edge;
      end else if (sel_edge) begin
         pending_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending     <= 1'b0;
         adc_trigger <= 1'b0;
         trig_count  <= '0;
      end else begin
         pending     <= pending_nxt;
         adc_trigger <= issue;
         if (issue) begin
            trig_count <= trig_count + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Overrun tracking; a clear in the same cycle as a loss wins.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun   <= 1'b0;
         ovr_count <= '0;
      end else if (ovr_clr) begin
         overrun   <= 1'b0;
         ovr_count <= '0;
      end else if (lost_edge) begin
         overrun <= 1'b1;
         if (ovr_count != {OVR_W{1'b1}}) begin
            ovr_count <= ovr_count + OVR_W'(1);
         end
      end
   end

endmodule : axioma_adc_trigger

// File: tb/tb_axioma_adc_trigger.sv
// -----------------------------------------------------------------------------
// tb_axioma_adc_trigger
// Directed bench for axioma_adc_trigger. A behavioural model of the trigger
// rules is compared against the DUT on every cycle out of reset, and the
// directed sequences add hand-computed literal expectations. The trigger
// counter is built 8 bits wide so its wrap is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_axioma_adc_trigger;

   localparam int CNT_W = 8;
   localparam int OVR_W = 8;
   localparam int CNT_MOD = 1 << CNT_W;
   localparam int OVR_MAX = (1 << OVR_W) - 1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [2:0]       adts;
   logic             adate, aden, adc_busy, adc_done;
   logic             acomp_out, int0_flag, tc0_compa, tc0_ovf;
   logic             tc1_compb, tc1_ovf, tc1_capt, ovr_clr;
   logic             adc_trigger, pending, overrun;
   logic [OVR_W-1:0] ovr_count;
   logic [CNT_W-1:0] trig_count;

   always #5 clk = ~clk;

   axioma_adc_trigger #(
      .CNT_W (CNT_W),
      .OVR_W (OVR_W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .adts        (adts),
      .adate       (adate),
      .aden        (aden),
      .adc_busy    (adc_busy),
      .adc_done    (adc_done),
      .acomp_out   (acomp_out),
      .int0_flag   (int0_flag),
      .tc0_compa   (tc0_compa),
      .tc0_ovf     (tc0_ovf),
      .tc1_compb   (tc1_compb),
      .tc1_ovf     (tc1_ovf),
      .tc1_capt    (tc1_capt),
      .ovr_clr     (ovr_clr),
      .adc_trigger (adc_trigger),
      .pending     (pending),
      .overrun     (overrun),
      .ovr_count   (ovr_count),
      .trig_count  (trig_count)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: state kept as plain bits and integers
   // ---------------------------------------------------------------------
   bit [7:0] m_last;      // source levels seen at the previous clock
   bit       m_pend, m_trig, m_ovr;
   int       m_oc, m_tc;
   bit [7:0] m_now;
   bit       m_go, m_seen, m_drop;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_last = '0; m_pend = 0; m_trig = 0; m_ovr = 0; m_oc = 0; m_tc = 0;
      end else begin
         m_now  = {tc1_capt, tc1_ovf, tc1_compb, tc0_ovf, tc0_compa, int0_flag, acomp_out, adc_done};
         m_seen = m_now[adts] && !m_last[adts];
         m_last = m_now;
         m_drop = 0;
         if (!(aden && adate)) begin
            m_pend = 0;
            m_trig = 0;
         end else begin
            m_go   = m_pend && !adc_busy && !m_trig;
            m_drop = m_seen && m_pend && !m_go;
            m_trig = m_go;
            if (m_go) begin
               m_tc   = (m_tc + 1) % CNT_MOD;
               m_pend = m_seen;
            end else if (m_seen) begin
               m_pend = 1;
            end
         end
         if (ovr_clr) begin
            m_ovr = 0;
            m_oc  = 0;
         end else if (m_drop) begin
            m_ovr = 1;
            m_oc  = (m_oc < OVR_MAX) ? m_oc + 1 : OVR_MAX;
         end
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         check("cyc_trigger", 32'(adc_trigger), 32'(m_trig));
         check("cyc_pending", 32'(pending), 32'(m_pend));
         check("cyc_overrun", 32'(overrun), 32'(m_ovr));
         check("cyc_ovr_count", 32'(ovr_count), m_oc);
         check("cyc_trig_count", 32'(trig_count), m_tc);
      end
   end

   // ---------------------------------------------------------------------
   // Directed stimulus
   // ---------------------------------------------------------------------
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_trig(input int n, output int hits);
      hits = 0;
      repeat (n) begin
         @(negedge clk);
         if (adc_trigger) hits++;
      end
   endtask

   int n, last, ntrig, bcnt, start, seen, target, cyc;
   bit saw_wrap;
   logic [CNT_W-1:0] prev_tc;

   initial begin
      reset_n = 0; adts = 3'd0; adate = 0; aden = 0; adc_busy = 0; adc_done = 0;
      acomp_out = 0; int0_flag = 0; tc0_compa = 0; tc0_ovf = 0;
      tc1_compb = 0; tc1_ovf = 0; tc1_capt = 0; ovr_clr = 0;

      // Reset state
      tick(3);
      check("rst_trigger", 32'(adc_trigger), 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_ovr_count", 32'(ovr_count), 0);
      check("rst_trig_count", 32'(trig_count), 0);
      reset_n = 1; aden = 1; adate = 1;

      // Latency: Timer0 overflow edge -> pending next cycle -> pulse after
      adts = 3'd4;
      tick(2);
      tc0_ovf = 1;
      tick();
      check("lat_pending_n1", 32'(pending), 1);
      check("lat_trigger_n1", 32'(adc_trigger), 0);
      tick();
      check("lat_trigger_n2", 32'(adc_trigger), 1);
      check("lat_count", 32'(trig_count), 1);
      tick();
      check("lat_pulse_width", 32'(adc_trigger), 0);
      tc0_ovf = 0;
      tick(2);

      // Overrun while the ADC is busy
      adts = 3'd1; adc_busy = 1;
      tick();
      repeat (3) begin
         acomp_out = 1; tick();
         acomp_out = 0; tick();
      end
      check("ovr_pending", 32'(pending), 1);
      check("ovr_flag", 32'(overrun), 1);
      check("ovr_count2", 32'(ovr_count), 2);
      adc_busy = 0;
      count_trig(6, n);
      check("ovr_one_trigger", n, 1);
      check("ovr_trig_count", 32'(trig_count), 2);
      ovr_clr = 1; tick(); ovr_clr = 0;
      check("clr_overrun", 32'(overrun), 0);
      check("clr_ovr_count", 32'(ovr_count), 0);

      // Switching onto a source that is already high makes no edge
      adts = 3'd2; tc1_capt = 1;
      tick(3);
      adts = 3'd7;
      count_trig(5, n);
      check("sw_no_trigger", n, 0);
      tc1_capt = 0; tick();
      tc1_capt = 1;
      count_trig(4, n);
      check("sw_real_edge", n, 1);
      tc1_capt = 0;
      tick(2);

      // Free-running: software start, then ADC model answers 20 cycles later
      adts = 3'd0;
      tick();
      adc_done = 1; tick(); adc_done = 0;
      last = -1; ntrig = 0; bcnt = 0;
      for (int c = 0; c < 150; c++) begin
         @(negedge clk);
         adc_done = 0;
         if (adc_trigger) begin
            if (last >= 0) check("free_gap", c - last, 21);
            last = c; ntrig++;
            adc_busy = 1; bcnt = 0;
         end else if (adc_busy) begin
            bcnt++;
            if (bcnt == 19) begin
               adc_busy = 0; adc_done = 1;
            end
         end
      end
      check("free_count", ntrig, 8);
      adc_busy = 0; adc_done = 0;
      tick(2);

      // Disarm mid-request, then asynchronous reset mid-request
      adts = 3'd3; adc_busy = 1;
      tc0_compa = 1; tick(); tc0_compa = 0;
      check("dis_pending_set", 32'(pending), 1);
      adate = 0; tick();
      check("dis_pending_drop", 32'(pending), 0);
      adc_busy = 0;
      count_trig(4, n);
      check("dis_no_trigger", n, 0);
      adate = 1; adc_busy = 1;
      tc0_compa = 1; tick(); tc0_compa = 0;
      check("arst_pending_set", 32'(pending), 1);
      #2 reset_n = 0;
      #1;
      check("arst_trigger", 32'(adc_trigger), 0);
      check("arst_pending", 32'(pending), 0);
      check("arst_overrun", 32'(overrun), 0);
      check("arst_ovr_count", 32'(ovr_count), 0);
      check("arst_trig_count", 32'(trig_count), 0);
      tick(2);
      reset_n = 1;
      tick();

      // Overrun counter saturation, and clear beating a simultaneous loss
      adts = 3'd5;
      for (int i = 0; i < 260; i++) begin
         tc1_compb = 1; tick();
         tc1_compb = 0; tick();
      end
      check("sat_flag", 32'(overrun), 1);
      check("sat_count", 32'(ovr_count), 255);
      ovr_clr = 1; tc1_compb = 1; tick();
      ovr_clr = 0; tc1_compb = 0;
      check("clr_wins_flag", 32'(overrun), 0);
      check("clr_wins_count", 32'(ovr_count), 0);
      check("clr_wins_pending", 32'(pending), 1);
      tick();
      tc1_compb = 1; tick(); tc1_compb = 0;
      check("post_clr_count", 32'(ovr_count), 1);
      adc_busy = 0;
      tick(4);
      check("sat_drain_count", 32'(trig_count), 1);

      // Trigger counter wrap
      adts = 3'd6;
      start = m_tc;
      target = CNT_MOD - start + 3;
      seen = 0; cyc = 0; saw_wrap = 0;
      prev_tc = trig_count;
      while (seen < target && cyc < 2000) begin
         tc1_ovf = ~tc1_ovf;
         @(negedge clk);
         cyc++;
         if (adc_trigger) seen++;
         if (prev_tc == '1 && trig_count == '0) saw_wrap = 1;
         prev_tc = trig_count;
      end
      check("wrap_budget", 32'(seen >= target), 1);
      tc1_ovf = 0;
      repeat (6) begin
         @(negedge clk);
         if (adc_trigger) seen++;
      end
      check("wrap_seen", 32'(saw_wrap), 1);
      check("wrap_value", 32'(trig_count), (start + seen) % CNT_MOD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_axioma_adc_trigger
